// File: rtl/decode.sv
// decode: instruction decode stage downstream of fetch.
// Consumes fetch's two-word window each cycle, issues registered operand
// fields for 16- or 32-bit instructions, and drives the branch/jump redirect
// controls (pcjumpenable / pcchange / pclocation) back to fetch, holding them
// steady for JUMP_HOLD cycles while fetch re-steers.
// Optional feature macro: DECODE_32BIT_EN enables 32-bit decode and the
// SECOND state that swallows the extension word. Without it every word is
// decoded as a 16-bit instruction.
module decode #(
  parameter int JUMP_HOLD = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fetchoutput,
  input  logic [19:0] previous_programcounter,
  input  logic        flush,
  output logic        decode_valid,
  output logic        decode_is32,
  output logic [1:0]  decode_class,
  output logic [7:0]  decode_opcode,
  output logic [5:0]  decode_dest,
  output logic [5:0]  decode_srca,
  output logic [5:0]  decode_srcb,
  output logic [19:0] decode_pc,
  output logic [2:0]  pcjumpenable,
  output logic [8:0]  pcchange,
  output logic [5:0]  pclocation
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1
`ifdef DECODE_32BIT_EN
    , ST_SECOND = 2'd2
`endif
  } state_t;

  typedef struct packed {
    logic        is32;
    logic [1:0]  cls;
    logic [7:0]  opcode;
    logic [5:0]  dest;
    logic [5:0]  srca;
    logic [5:0]  srcb;
    logic [19:0] pc;
  } fields_t;

  typedef struct packed {
    logic [2:0] kind;
    logic [8:0] change;
    logic [5:0] location;
  } redirect_t;

  localparam logic [3:0] HOLD_INIT = 4'(JUMP_HOLD);

  state_t    state, state_nxt;
  logic [3:0] hold_cnt, hold_cnt_nxt;
  logic      valid_q, valid_nxt;
  fields_t   fields_q, fields_nxt, decoded;
  redirect_t redirect_q, redirect_nxt;

  logic [15:0] word;
  logic [15:0] ext;
  logic        is_long;
  logic [3:0]  ext_opcode;
  logic [2:0]  ext_dest, ext_srca, ext_srcb;
  logic [8:0]  rel_offset;
  logic        is_bubble;
  logic        is_flow;
  logic        hold_done;
  logic [2:0]  jump_kind;

  assign word = fetchoutput[31:16];
  assign ext  = fetchoutput[15:0];

`ifdef DECODE_32BIT_EN
  // The extension word supplies the high halves of opcode and register
  // fields and the top bits of a long relative offset.
  logic unused_ext_msbs;
  assign is_long         = word[15];
  assign ext_opcode      = is_long ? ext[12:9] : 4'd0;
  assign ext_dest        = is_long ? ext[8:6]  : 3'd0;
  assign ext_srca        = is_long ? ext[5:3]  : 3'd0;
  assign ext_srcb        = is_long ? ext[2:0]  : 3'd0;
  assign rel_offset      = is_long ? {ext[2:0], word[5:0]} : {{3{word[5]}}, word[5:0]};
  assign unused_ext_msbs = ^ext[15:13];
`else
  // Every word is a 16-bit instruction; the long flag and next word are unused.
  logic unused_long_bits;
  assign is_long          = 1'b0;
  assign ext_opcode       = 4'd0;
  assign ext_dest         = 3'd0;
  assign ext_srca         = 3'd0;
  assign ext_srcb         = 3'd0;
  assign rel_offset       = {{3{word[5]}}, word[5:0]};
  assign unused_long_bits = ^{word[15], ext};
`endif

  assign is_bubble = (word == 16'h0001);
  // Flow class with opcode low nibble 0..3 is a redirect; other flow opcodes issue plainly.
  assign is_flow   = (word[14:13] == 2'b10) && (word[12:11] == 2'b00);
  assign jump_kind = {1'b0, word[10:9]} + 3'd1;
  assign hold_done = (hold_cnt <= 4'd1);

  assign decoded = '{
    is32:   is_long,
    cls:    word[14:13],
    opcode: {ext_opcode, word[12:9]},
    dest:   {ext_dest, word[8:6]},
    srca:   {ext_srca, word[5:3]},
    srcb:   {ext_srcb, word[2:0]},
    pc:     previous_programcounter - 20'd2
  };

  // State register and hold counter.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state    <= ST_RUN;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Next-state logic: flush returns to RUN, otherwise walk the decode FSM.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable and no latch is inferred.
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    if (flush) begin
      state_nxt    = ST_RUN;
      hold_cnt_nxt = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!is_bubble) begin
            if (is_flow) begin
              state_nxt    = ST_HOLD;
              hold_cnt_nxt = HOLD_INIT;
            end
`ifdef DECODE_32BIT_EN
            else if (is_long) begin
              state_nxt = ST_SECOND;
            end
`endif
          end
        end
        ST_HOLD: begin
          if (hold_done) begin
            state_nxt    = ST_RUN;
            hold_cnt_nxt = '0;
          end else begin
            hold_cnt_nxt = hold_cnt - 4'd1;
          end
        end
`ifdef DECODE_32BIT_EN
        ST_SECOND: state_nxt = ST_RUN;
`endif
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // Output logic: next values of the issue fields and redirect controls.
  always_comb begin
    valid_nxt    = 1'b0;
    fields_nxt   = fields_q;
    redirect_nxt = redirect_q;
    if (flush) begin
      redirect_nxt = '0;
    end else begin
      case (state)
        ST_RUN: begin
          redirect_nxt = '0;
          if (!is_bubble) begin
            valid_nxt  = 1'b1;
            fields_nxt = decoded;
            if (is_flow) begin
              redirect_nxt = '{kind: jump_kind, change: rel_offset, location: word[5:0]};
            end
          end
        end
        ST_HOLD: begin
          if (hold_done) redirect_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  // Output registers; everything clears on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      fields_q   <= '0;
      redirect_q <= '0;
    end else begin
      valid_q    <= valid_nxt;
      fields_q   <= fields_nxt;
      redirect_q <= redirect_nxt;
    end
  end

  assign decode_valid  = valid_q;
  assign decode_is32   = fields_q.is32;
  assign decode_class  = fields_q.cls;
  assign decode_opcode = fields_q.opcode;
  assign decode_dest   = fields_q.dest;
  assign decode_srca   = fields_q.srca;
  assign decode_srcb   = fields_q.srcb;
  assign decode_pc     = fields_q.pc;
  assign pcjumpenable  = redirect_q.kind;
  assign pcchange      = redirect_q.change;
  assign pclocation    = redirect_q.location;

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed vector table followed by randomized windows checked
// against a behavioural model of the decode stage.
`timescale 1ns/1ps
module tb_decode;

  localparam int JUMP_HOLD = 2;
`ifdef DECODE_32BIT_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fetchoutput;
  logic [19:0] previous_programcounter;
  logic        flush;
  logic        decode_valid;
  logic        decode_is32;
  logic [1:0]  decode_class;
  logic [7:0]  decode_opcode;
  logic [5:0]  decode_dest;
  logic [5:0]  decode_srca;
  logic [5:0]  decode_srcb;
  logic [19:0] decode_pc;
  logic [2:0]  pcjumpenable;
  logic [8:0]  pcchange;
  logic [5:0]  pclocation;

  decode #(.JUMP_HOLD(JUMP_HOLD)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .fetchoutput             (fetchoutput),
    .previous_programcounter (previous_programcounter),
    .flush                   (flush),
    .decode_valid            (decode_valid),
    .decode_is32             (decode_is32),
    .decode_class            (decode_class),
    .decode_opcode           (decode_opcode),
    .decode_dest             (decode_dest),
    .decode_srca             (decode_srca),
    .decode_srcb             (decode_srcb),
    .decode_pc               (decode_pc),
    .pcjumpenable            (pcjumpenable),
    .pcchange                (pcchange),
    .pclocation              (pclocation)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] obs_redirect();
    return {45'd0, decode_valid, pcjumpenable, pcchange, pclocation};
  endfunction

  function automatic logic [63:0] obs_fields();
    return {15'd0, decode_is32, decode_class, decode_opcode, decode_dest, decode_srca, decode_srcb, decode_pc};
  endfunction

  // Drive one window at the falling edge, let the rising edge take it, then settle.
  task automatic apply(input logic [31:0] win, input logic [19:0] pc, input logic fl, input logic rs);
    @(negedge clock);
    fetchoutput             = win;
    previous_programcounter = pc;
    flush                   = fl;
    reset                   = rs;
    @(posedge clock);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic        is32;
    logic [1:0]  cls;
    logic [7:0]  opc;
    logic [5:0]  d;
    logic [5:0]  a;
    logic [5:0]  b;
    logic [19:0] pc;
    logic [2:0]  pje;
    logic [8:0]  chg;
    logic [5:0]  loc;
  } exp_t;

  exp_t m;
  int   skip_left = 0;   // upcoming windows that will be swallowed

  function automatic int bits_of(input int x, input int lsb, input int width);
    return (x >> lsb) % (1 << width);
  endfunction

  function automatic void model_step(input logic [31:0] win, input logic [19:0] pc, input logic fl, input logic rs);
    int w, e, cls, opc_lo, lo6, hi_opc, hi_d, hi_a, hi_b, offset;
    bit long_ins;
    w = int'(win[31:16]);
    e = int'(win[15:0]);
    if (rs) begin
      m = '0;
      skip_left = 0;
    end else if (fl) begin
      m.valid = 1'b0; m.pje = '0; m.chg = '0; m.loc = '0;
      skip_left = 0;
    end else if (skip_left > 0) begin
      m.valid = 1'b0;
      skip_left--;
      if (skip_left == 0) begin
        m.pje = '0; m.chg = '0; m.loc = '0;
      end
    end else if (w == 1) begin
      m.valid = 1'b0;
    end else begin
      long_ins = LONG_EN && (w >= 32768);
      cls      = bits_of(w, 13, 2);
      opc_lo   = bits_of(w, 9, 4);
      lo6      = w % 64;
      hi_opc   = long_ins ? bits_of(e, 9, 4) : 0;
      hi_d     = long_ins ? bits_of(e, 6, 3) : 0;
      hi_a     = long_ins ? bits_of(e, 3, 3) : 0;
      hi_b     = long_ins ? bits_of(e, 0, 3) : 0;
      m.valid  = 1'b1;
      m.is32   = long_ins;
      m.cls    = 2'(cls);
      m.opc    = 8'(hi_opc * 16 + opc_lo);
      m.d      = 6'(hi_d * 8 + bits_of(w, 6, 3));
      m.a      = 6'(hi_a * 8 + bits_of(w, 3, 3));
      m.b      = 6'(hi_b * 8 + bits_of(w, 0, 3));
      m.pc     = 20'((int'(pc) + 1048576 - 2) % 1048576);
      if (cls == 2 && opc_lo < 4) begin
        offset    = long_ins ? bits_of(e, 0, 3) * 64 + lo6 : (lo6 >= 32 ? lo6 - 64 + 512 : lo6);
        m.pje     = 3'(opc_lo + 1);
        m.chg     = 9'(offset);
        m.loc     = 6'(lo6);
        skip_left = JUMP_HOLD;
      end else if (long_ins) begin
        skip_left = 1;
      end
    end
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [31:0] win;
    logic [19:0] pc;
    logic        fl;
    logic        rs;
    logic        v;
    logic [2:0]  pje;
    logic [8:0]  chg;
    logic [5:0]  loc;
    logic        chkf;
    logic        is32;
    logic [1:0]  cls;
    logic [7:0]  opc;
    logic [5:0]  d;
    logic [5:0]  a;
    logic [5:0]  b;
    logic [19:0] dpc;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  initial begin
    logic [31:0] win;
    logic [19:0] pc;
    logic        fl, rs;
    int          r;

    reset = 1'b1; flush = 1'b0; fetchoutput = '0; previous_programcounter = '0;
    m = '0;

    //          win           pc         fl    rs    v     pje   chg     loc    chkf  is32  cls    opc    d      a      b      dpc
    vecs[0]  = '{32'h0000_0000, 20'h00000, 1'b0, 1'b1, 1'b0, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[1]  = '{32'h029C_0000, 20'h00010, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd0, 8'h01, 6'd2,  6'd3, 6'd4, 20'h0000E};
    vecs[2]  = '{32'h403E_0000, 20'h00012, 1'b0, 1'b0, 1'b1, 3'd1, 9'h1FE, 6'h3E, 1'b1, 1'b0, 2'd2, 8'h00, 6'd0,  6'd7, 6'd6, 20'h00010};
    vecs[3]  = '{32'h029C_0000, 20'h00014, 1'b0, 1'b0, 1'b0, 3'd1, 9'h1FE, 6'h3E, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[4]  = '{32'h029C_0000, 20'h00016, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 6'h00, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[5]  = '{32'h029C_0000, 20'h00001, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd0, 8'h01, 6'd2,  6'd3, 6'd4, 20'hFFFFF};
    vecs[6]  = '{32'h0001_029C, 20'h00002, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 6'h00, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[7]  = '{32'h422A_0000, 20'h00020, 1'b0, 1'b0, 1'b1, 3'd2, 9'h1EA, 6'h2A, 1'b1, 1'b0, 2'd2, 8'h01, 6'd0,  6'd5, 6'd2, 20'h0001E};
    vecs[8]  = '{32'h029C_0000, 20'h00022, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 6'h00, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[9]  = '{32'h029C_0000, 20'h00024, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd0, 8'h01, 6'd2,  6'd3, 6'd4, 20'h00022};
    vecs[10] = '{32'h4462_0000, 20'h00100, 1'b0, 1'b0, 1'b1, 3'd3, 9'h1E2, 6'h22, 1'b1, 1'b0, 2'd2, 8'h02, 6'd1,  6'd4, 6'd2, 20'h000FE};
    vecs[11] = '{32'h029C_0000, 20'h00102, 1'b0, 1'b1, 1'b0, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[12] = '{32'h467F_0000, 20'h00002, 1'b0, 1'b0, 1'b1, 3'd4, 9'h1FF, 6'h3F, 1'b1, 1'b0, 2'd2, 8'h03, 6'd1,  6'd7, 6'd7, 20'h00000};
    vecs[13] = '{32'h029C_0000, 20'h00004, 1'b0, 1'b0, 1'b0, 3'd4, 9'h1FF, 6'h3F, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[14] = '{32'h029C_0000, 20'h00006, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 6'h00, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[15] = '{32'h4800_0000, 20'h00005, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd2, 8'h04, 6'd0,  6'd0, 6'd0, 20'h00003};
    vecs[16] = '{32'h7FFF_0000, 20'h80000, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd3, 8'h0F, 6'd7,  6'd7, 6'd7, 20'h7FFFE};
    vecs[17] = '{32'h0001_FFFF, 20'h00000, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 6'h00, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    // Multi-cycle sequences around the 32-bit window (expectations depend on the build).
    vecs[18] = '{32'h829C_0040, 20'h00040, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b1, LONG_EN, 2'd0, 8'h01, (LONG_EN ? 6'd10 : 6'd2), 6'd3, 6'd4, 20'h0003E};
    vecs[19] = '{32'h029C_0000, 20'h00042, 1'b0, 1'b0, !LONG_EN, 3'd0, 9'h000, 6'h00, !LONG_EN, 1'b0, 2'd0, 8'h01, 6'd2, 6'd3, 6'd4, 20'h00040};
    vecs[20] = '{32'h029C_0000, 20'h00044, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd0, 8'h01, 6'd2,  6'd3, 6'd4, 20'h00042};
    vecs[21] = '{32'hC03E_0005, 20'h00050, 1'b0, 1'b0, 1'b1, 3'd1, (LONG_EN ? 9'h17E : 9'h1FE), 6'h3E, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0, 6'd0, 6'd0, 20'h00000};
    vecs[22] = '{32'h029C_0000, 20'h00052, 1'b0, 1'b0, 1'b0, 3'd1, (LONG_EN ? 9'h17E : 9'h1FE), 6'h3E, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0, 6'd0, 6'd0, 20'h00000};
    vecs[23] = '{32'h029C_0000, 20'h00054, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 6'h00, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[24] = '{32'h029C_0000, 20'h00060, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd0, 8'h01, 6'd2,  6'd3, 6'd4, 20'h0005E};
    vecs[25] = '{32'h829C_0040, 20'h00070, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[26] = '{32'h0001_0000, 20'h00072, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 6'h00, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[27] = '{32'h029C_0000, 20'h00074, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd0, 8'h01, 6'd2,  6'd3, 6'd4, 20'h00072};
    vecs[28] = '{32'h829C_0040, 20'h00080, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[29] = '{32'h029C_0000, 20'h00082, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 6'h00, 1'b0, 1'b0, 2'd0, 8'h00, 6'd0,  6'd0, 6'd0, 20'h00000};
    vecs[30] = '{32'h029C_0000, 20'h00084, 1'b0, 1'b0, 1'b1, 3'd0, 9'h000, 6'h00, 1'b1, 1'b0, 2'd0, 8'h01, 6'd2,  6'd3, 6'd4, 20'h00082};

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].win, vecs[i].pc, vecs[i].fl, vecs[i].rs);
      model_step(vecs[i].win, vecs[i].pc, vecs[i].fl, vecs[i].rs);
      check($sformatf("vec%0d_redirect", i), obs_redirect(),
            {45'd0, vecs[i].v, vecs[i].pje, vecs[i].chg, vecs[i].loc});
      if (vecs[i].chkf)
        check($sformatf("vec%0d_fields", i), obs_fields(),
              {15'd0, vecs[i].is32, vecs[i].cls, vecs[i].opc, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].dpc});
    end

    // Randomized windows against the model, starting from a clean reset.
    apply(32'h0, 20'h0, 1'b0, 1'b1);
    model_step(32'h0, 20'h0, 1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      win = {16'h0001, 16'($urandom)};
      else if (r < 45) win = {1'($urandom), 2'b10, 2'b00, 11'($urandom), 16'($urandom)};
      else             win = $urandom;
      fl = ($urandom_range(0, 99) < 4);
      rs = ($urandom_range(0, 199) == 0);
      pc = 20'($urandom);
      apply(win, pc, fl, rs);
      model_step(win, pc, fl, rs);
      check($sformatf("rand%0d_redirect", i), obs_redirect(),
            {45'd0, m.valid, m.pje, m.chg, m.loc});
      if (m.valid)
        check($sformatf("rand%0d_fields", i), obs_fields(),
              {15'd0, m.is32, m.cls, m.opc, m.d, m.a, m.b, m.pc});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
